// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory-side request/ready interface.
//   state_e : responder FSM states (IDLE, BUSY, DONE)
//   op_e    : latched operation kind (OP_READ, OP_WRITE)
//   MEM_DATA_WIDTH / MEM_ADDR_WIDTH : default widths shared with the cache system
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_ADDR_WIDTH = 16;

endpackage

// File: rtl/latency_counter.sv
// Down-counter that times one memory access.
//   clk      : clock
//   rst      : asynchronous active-low reset
//   load     : load load_val (takes priority over dec)
//   load_val : start value, LATENCY-1
//   dec      : decrement by one; holds at zero
//   zero     : counter currently reads zero
module latency_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/main_memory_responder.sv
// Word-addressed main-memory model answering cache miss / write-back requests.
// A request (level-held read or write enable) is accepted in IDLE, takes
// LATENCY cycles with mem_ready low, then parks in DONE until both enables
// drop, so a held request cannot re-trigger.
//
// Ports:
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   mem_address    : word address
//   mem_write_data : write data
//   mem_read_en    : read request (level)
//   mem_write_en   : write request (level); wins over a simultaneous read
//   mem_read_data  : registered read data, held until the next read completes
//   mem_ready      : 1 = idle/complete, 0 = access in progress
//   mem_err        : sticky, read and write requested together
//   rd_count       : completed reads (saturating)
//   wr_count       : completed writes (saturating)
//
// Optional feature macro: MEM_ACCESS_STATS_EN enables the access counters;
// without it rd_count/wr_count are tied to zero.
//
// The storage array "mem" lives in this module so the backdoor path is DUT.mem.
module main_memory_responder
  import mem_if_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_read_en,
  input  logic                  mem_write_en,
  output logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_ready,
  output logic                  mem_err,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  if ((LATENCY < 1) || (LATENCY > 255)) begin : g_bad_latency
    $error("main_memory_responder: LATENCY must be in 1..255");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic                  cnt_load, cnt_dec, cnt_zero;
  logic                  mem_we;

  latency_counter #(
    .CNT_W(CNT_W)
  ) u_latency_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(LOAD_VAL),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ready_d  = ready_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read_en || mem_write_en) begin
          addr_d   = mem_address;
          wdata_d  = mem_write_data;
          op_d     = mem_write_en ? OP_WRITE : OP_READ;
          err_d    = err_q | (mem_read_en & mem_write_en);
          cnt_load = 1'b1;
          ready_d  = 1'b0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_zero) begin
          if (op_q == OP_WRITE) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem[addr_q];
          end
          ready_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        // Park here while the cache still holds its request.
        if (!mem_read_en && !mem_write_en) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // ---- control / output registers ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // ---- request capture (data only, no reset) ----
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Reset forces state_q to IDLE asynchronously, so an aborted write never commits.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign mem_read_data = rdata_q;
  assign mem_ready     = ready_q;
  assign mem_err       = err_q;

`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic        rd_done, wr_done;

  assign rd_done = (state_q == BUSY) && cnt_zero && (op_q == OP_READ);
  assign wr_done = (state_q == BUSY) && cnt_zero && (op_q == OP_WRITE);

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_done && (rd_cnt_q != 16'hFFFF)) rd_cnt_d = rd_cnt_q + 16'd1;
    if (wr_done && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = 16'd0;
  assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_main_memory_responder.sv
// Testbench for main_memory_responder: directed vector table, hand-written
// DONE-hold and reset-abort sequences, then randomized accesses checked
// against an associative-array memory model.
module tb_main_memory_responder;

  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_read_en;
  logic          mem_write_en;
  logic [DW-1:0] mem_read_data;
  logic          mem_ready;
  logic          mem_err;
  logic [15:0]   rd_count;
  logic [15:0]   wr_count;

  main_memory_responder #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LATENCY   (LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_en   (mem_read_en),
    .mem_write_en  (mem_write_en),
    .mem_read_data (mem_read_data),
    .mem_ready     (mem_ready),
    .mem_err       (mem_err),
    .rd_count      (rd_count),
    .wr_count      (wr_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] ref_rdata;
  logic          ref_err;
  int            ref_rd;
  int            ref_wr;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef MEM_ACCESS_STATS_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return 16'd0 + 16'(n * 0);
`endif
  endfunction

  task automatic model_apply(input logic rd, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
    if (wr) begin
      ref_mem[int'(a)] = d;
      ref_wr++;
      if (rd) ref_err = 1'b1;
    end else if (rd) begin
      ref_rdata = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 'x;
      ref_rd++;
    end
  endtask

  task automatic model_reset();
    ref_rdata = '0;
    ref_err   = 1'b0;
    ref_rd    = 0;
    ref_wr    = 0;
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic run_access(input logic rd, input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input int hold,
                            output logic [DW-1:0] rdata_o, output logic err_o);
    logic [DW-1:0] old;
    int lowc;
    old            = dut.mem[addr];
    mem_address    = addr;
    mem_write_data = data;
    mem_read_en    = rd;
    mem_write_en   = wr;
    @(posedge clk);
    @(negedge clk);
    // Inputs changed during BUSY must be ignored.
    mem_address    = ~addr;
    mem_write_data = ~data;
    lowc = 0;
    while (!mem_ready && lowc < 300) begin
      lowc++;
      if (wr && lowc == LAT && old !== data) chk("mem_before_commit", dut.mem[addr], old);
      @(negedge clk);
    end
    chk("ready_low_cycles", 32'(lowc), 32'(LAT));
    if (wr) chk("mem_after_commit", dut.mem[addr], data);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_ready", 32'(mem_ready), 32'd1);
    end
    rdata_o      = mem_read_data;
    err_o        = mem_err;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] rdv;
    logic          errv;
    logic [DW-1:0] old2000;
    logic [AW-1:0] pool [8];

    vecs[0] = '{1'b0, 1'b1, 16'h5000, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'h5000, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 16'h0001, 32'h0000_0011, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 16'h0001, 32'h0,        32'h0000_0011, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 16'h1000, 32'h12345678, 32'h0000_0011, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 16'h1000, 32'h0,        32'h12345678, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 16'h5000, 32'h0,        32'hDEADBEEF, 1'b1};

    rst            = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(mem_ready), 32'd1);
    chk("reset_rdata", mem_read_data, 32'd0);
    chk("reset_err", 32'(mem_err), 32'd0);
    chk("reset_rd_count", 32'(rd_count), 32'd0);
    chk("reset_wr_count", 32'(wr_count), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, rdv, errv);
      model_apply(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d_rdata", i), rdv, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(errv), 32'(vecs[i].exp_err));
    end
    chk("table_rd_count", 32'(rd_count), 32'(exp_cnt(ref_rd)));
    chk("table_wr_count", 32'(wr_count), 32'(exp_cnt(ref_wr)));

    // Read held high in DONE for 3 cycles, then a fresh read right after
    run_access(1'b1, 1'b0, 16'h0001, 32'h0, 3, rdv, errv);
    model_apply(1'b1, 1'b0, 16'h0001, 32'h0);
    chk("hold_rdata", rdv, 32'h0000_0011);
    chk("hold_rd_count", 32'(rd_count), 32'(exp_cnt(ref_rd)));
    run_access(1'b1, 1'b0, 16'h5000, 32'h0, 0, rdv, errv);
    model_apply(1'b1, 1'b0, 16'h5000, 32'h0);
    chk("after_hold_rdata", rdv, 32'hDEADBEEF);

    // Reset two cycles into a write aborts it
    old2000        = dut.mem[16'h2000];
    mem_address    = 16'h2000;
    mem_write_data = 32'hCAFEF00D;
    mem_write_en   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_ready", 32'(mem_ready), 32'd1);
    mem_write_en = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("abort_mem_unchanged", dut.mem[16'h2000], old2000);
    chk("abort_err_cleared", 32'(mem_err), 32'd0);
    chk("abort_rdata_cleared", mem_read_data, 32'd0);
    chk("abort_rd_count", 32'(rd_count), 32'd0);

    // Randomized accesses on a small address pool
    for (int i = 0; i < 8; i++) begin
      pool[i] = AW'($urandom);
      run_access(1'b0, 1'b1, pool[i], $urandom, 0, rdv, errv);
      model_apply(1'b0, 1'b1, pool[i], dut.mem[pool[i]]);
    end
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          r, w;
      int            sel;
      a   = pool[$urandom_range(7)];
      d   = $urandom;
      sel = $urandom_range(9);
      r   = (sel < 5) || (sel == 9);
      w   = (sel >= 5);
      run_access(r, w, a, d, $urandom_range(2), rdv, errv);
      model_apply(r, w, a, d);
      chk($sformatf("rnd%0d_rdata", i), rdv, ref_rdata);
      chk($sformatf("rnd%0d_err", i), 32'(errv), 32'(ref_err));
      if (w) chk($sformatf("rnd%0d_mem", i), dut.mem[a], ref_mem[int'(a)]);
    end
    chk("rnd_rd_count", 32'(rd_count), 32'(exp_cnt(ref_rd)));
    chk("rnd_wr_count", 32'(wr_count), 32'(exp_cnt(ref_wr)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
